fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 79 +++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issues one imem request at PC,
// latches the returned word, presents it to decode and advances PC on consume.
// A taken branch to a misaligned target sets a sticky flag and halts until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  output logic [31:0]         Instr,
  output logic                InstrValid,
  input  logic                InstrReady,
  input  logic                PCSrc,
  input  logic [31:0]         ImmExt,
  output logic [31:0]         PC,
  output logic [31:0]         PCPlus4,
  output logic [31:0]         PCTarget,
  output logic                misalign
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0] state;
  logic       consume;

  // Address arithmetic and decoded outputs; all wrap modulo 2^32.
  always_comb begin
    PCPlus4        = PC + 32'd4;
    PCTarget       = PC + ImmExt;
    imem.imem_req  = (state == S_FETCH);
    imem.imem_addr = PC;
    InstrValid     = (state == S_VALID);
    consume        = (state == S_VALID) && InstrReady;
  end

  // FSM, PC, instruction latch and sticky misalign flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      PC       <= RESET_PC;
      Instr    <= NOP;
      misalign <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: if (imem.imem_ready) state <= S_WAIT;
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            Instr <= imem.imem_rdata;
            state <= S_VALID;
          end
        end
        S_VALID: begin
          if (consume) begin
            if (!PCSrc) begin
              PC    <= PCPlus4;
              state <= S_FETCH;
            end else if (PCTarget[1:0] == 2'b00) begin
              PC    <= PCTarget;
              state <= S_FETCH;
            end else begin
              misalign <= 1'b1;
              state    <= S_HALT;
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
